// File: rtl/rst_seq_ctrl.sv
// Staged reset-release sequencer: synchronises en_req/pll_lock, then releases
// NUM_STAGES active-low resets LSB first. Optional lock timeout: RST_SEQ_TMO_EN.
module rst_seq_ctrl #(
    parameter int NUM_STAGES  = 4,
    parameter int CNT_W       = 8,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGE_GAP   = 8
`ifdef RST_SEQ_TMO_EN
    ,
    parameter int LOCK_TMO    = 200
`endif
) (
    input  logic                  ck,
    input  logic                  cdn,
    input  logic                  en_req,
    input  logic                  pll_lock,
    output logic [NUM_STAGES-1:0] rst_n_out,
    output logic                  seq_busy,
    output logic                  seq_done,
    output logic                  tmo_err
);

    localparam int STG_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
    localparam logic [STG_W-1:0] STG_LAST  = STG_W'(NUM_STAGES - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_LOCK = 3'd1,
        HOLD      = 3'd2,
        REL       = 3'd3,
        DONE      = 3'd4
    } state_t;

    logic                  en_meta_r, en_sync_r, lock_meta_r, lock_sync_r;
    state_t                state_r, state_nx_s;
    logic [CNT_W-1:0]      cnt_r, cnt_nx_s;
    logic [STG_W-1:0]      stg_r, stg_nx_s;
    logic [NUM_STAGES-1:0] rst_r, rst_nx_s;
    logic                  busy_r, done_r;

`ifdef RST_SEQ_TMO_EN
    localparam int TMO_W = $clog2(LOCK_TMO + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOCK_TMO - 1);
    logic [TMO_W-1:0] tcnt_r, tcnt_nx_s;
    logic             tmo_r, tmo_nx_s;
`endif

    // two-flop synchronisers for the asynchronous request and lock pins
    always_ff @(posedge ck or negedge cdn) begin
        if (!cdn) begin
            en_meta_r   <= 1'b0;
            en_sync_r   <= 1'b0;
            lock_meta_r <= 1'b0;
            lock_sync_r <= 1'b0;
        end else begin
            en_meta_r   <= en_req;
            en_sync_r   <= en_meta_r;
            lock_meta_r <= pll_lock;
            lock_sync_r <= lock_meta_r;
        end
    end

    // next-state, counters and reset-vector update
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        stg_nx_s   = stg_r;
        rst_nx_s   = rst_r;
`ifdef RST_SEQ_TMO_EN
        tcnt_nx_s  = tcnt_r;
        tmo_nx_s   = tmo_r;
`endif
        if ((state_r != IDLE) && !en_sync_r) begin
            state_nx_s = IDLE;
            cnt_nx_s   = {CNT_W{1'b0}};
            stg_nx_s   = {STG_W{1'b0}};
            rst_nx_s   = {NUM_STAGES{1'b0}};
        end else if ((state_r == HOLD || state_r == REL || state_r == DONE) && !lock_sync_r) begin
            // lock lost after it was seen: restart the whole sequence
            state_nx_s = WAIT_LOCK;
            cnt_nx_s   = {CNT_W{1'b0}};
            stg_nx_s   = {STG_W{1'b0}};
            rst_nx_s   = {NUM_STAGES{1'b0}};
`ifdef RST_SEQ_TMO_EN
            tcnt_nx_s  = {TMO_W{1'b0}};
`endif
        end else begin
            case (state_r)
                IDLE: begin
`ifdef RST_SEQ_TMO_EN
                    tcnt_nx_s = {TMO_W{1'b0}};
                    if (tmo_r) begin
                        // an enable low phase acknowledges the timeout
                        if (!en_sync_r) begin
                            tmo_nx_s = 1'b0;
                        end else begin
                            tmo_nx_s = 1'b1;
                        end
                    end else if (en_sync_r) begin
                        state_nx_s = WAIT_LOCK;
                        cnt_nx_s   = {CNT_W{1'b0}};
                    end else begin
                        state_nx_s = IDLE;
                    end
`else
                    if (en_sync_r) begin
                        state_nx_s = WAIT_LOCK;
                        cnt_nx_s   = {CNT_W{1'b0}};
                    end else begin
                        state_nx_s = IDLE;
                    end
`endif
                end
                WAIT_LOCK: begin
                    if (lock_sync_r) begin
                        state_nx_s = HOLD;
                        cnt_nx_s   = {CNT_W{1'b0}};
`ifdef RST_SEQ_TMO_EN
                    end else if (tcnt_r == TMO_LAST) begin
                        state_nx_s = IDLE;
                        tmo_nx_s   = 1'b1;
                        tcnt_nx_s  = {TMO_W{1'b0}};
                    end else begin
                        tcnt_nx_s  = tcnt_r + 1'b1;
`else
                    end else begin
                        state_nx_s = WAIT_LOCK;
`endif
                    end
                end
                HOLD: begin
                    if (cnt_r == HOLD_LAST) begin
                        state_nx_s  = REL;
                        cnt_nx_s    = {CNT_W{1'b0}};
                        stg_nx_s    = {STG_W{1'b0}};
                        rst_nx_s[0] = 1'b1;
                    end else begin
                        cnt_nx_s = cnt_r + 1'b1;
                    end
                end
                REL: begin
                    if (stg_r == STG_LAST) begin
                        state_nx_s = DONE;
                        cnt_nx_s   = {CNT_W{1'b0}};
                    end else if (cnt_r == GAP_LAST) begin
                        cnt_nx_s = {CNT_W{1'b0}};
                        stg_nx_s = stg_r + 1'b1;
                        rst_nx_s = rst_r | (NUM_STAGES'(2) << stg_r);
                    end else begin
                        cnt_nx_s = cnt_r + 1'b1;
                    end
                end
                DONE: begin
                    state_nx_s = DONE;
                end
                default: begin
                    state_nx_s = IDLE;
                    cnt_nx_s   = {CNT_W{1'b0}};
                    stg_nx_s   = {STG_W{1'b0}};
                    rst_nx_s   = {NUM_STAGES{1'b0}};
                end
            endcase
        end
    end

    // state, counters and outputs, all registered from the next-state decode
    always_ff @(posedge ck or negedge cdn) begin
        if (!cdn) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            stg_r   <= {STG_W{1'b0}};
            rst_r   <= {NUM_STAGES{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
            stg_r   <= stg_nx_s;
            rst_r   <= rst_nx_s;
            busy_r  <= (state_nx_s == WAIT_LOCK) || (state_nx_s == HOLD) || (state_nx_s == REL);
            done_r  <= (state_nx_s == DONE);
        end
    end

`ifdef RST_SEQ_TMO_EN
    // lock-timeout counter and sticky error flag
    always_ff @(posedge ck or negedge cdn) begin
        if (!cdn) begin
            tcnt_r <= {TMO_W{1'b0}};
            tmo_r  <= 1'b0;
        end else begin
            tcnt_r <= tcnt_nx_s;
            tmo_r  <= tmo_nx_s;
        end
    end
    assign tmo_err = tmo_r;
`else
    assign tmo_err = 1'b0;
`endif

    assign rst_n_out = rst_r;
    assign seq_busy  = busy_r;
    assign seq_done  = done_r;

endmodule
